// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT butterfly reduction stage.
// Holds the default coefficient width, modulus Q, Barrett shift K and the
// Barrett multiplier M = floor(2^K / Q), plus a constant function for M.
package ntt_pkg;

    localparam int          COEF_W = 32;
    localparam int          WIDE_W = 2 * COEF_W;
    localparam int unsigned Q      = 32'd8380417;
    localparam int          K      = WIDE_W;
    localparam int          Q_W    = $clog2(Q + 1);
    // floor(2^K / Q) needs at most K - Q_W + 1 bits
    localparam int          M_W    = K - Q_W + 1;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [WIDE_W-1:0] wide_t;

    // floor(2^k / q) by restoring long division of the (k+1)-bit dividend 1<<k.
    // Supports k <= 127 and q < 2^63.
    function automatic logic [127:0] barrett_m(input int k, input logic [63:0] q);
        logic [127:0] quo;
        logic [64:0]  rem;
        quo = '0;
        rem = '0;
        for (int i = k; i >= 0; i--) begin
            rem = {rem[63:0], (i == k)};
            if (rem >= {1'b0, q}) begin
                rem = rem - {1'b0, q};
                if (i < 128) quo[i] = 1'b1;
            end
        end
        return quo;
    endfunction

    localparam logic [127:0] BARRETT_M = barrett_m(K, 64'(Q));

endpackage

// File: rtl/ntt_barrett_lane.sv
// One lane of the 3-stage signed Barrett reduction datapath.
// S1: sign/abs, S2: quotient estimate, S3: correction + sign fix-up.
// Each stage register loads on its own enable; flow control lives in the top.
module ntt_barrett_lane
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = COEF_W,
    parameter int VAL_Q      = Q
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en1,
    input  logic                    en2,
    input  logic                    en3,
    input  logic [2*DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0]   r
);

    localparam int WW = 2 * DATA_WIDTH;
    localparam int RW = DATA_WIDTH + 2;   // holds r in [0, 3Q)

    localparam logic [127:0]  M_FULL = barrett_m(WW, 64'(VAL_Q));
    localparam logic [WW-1:0] M_K    = M_FULL[WW-1:0];
    localparam logic [WW-1:0] Q_WW   = WW'(VAL_Q);
    localparam logic [RW-1:0] Q_RW   = RW'(VAL_Q);

    logic                  s1, s2;
    logic [WW-1:0]         a1, a2, q2;
    logic [WW-1:0]         a_abs, q_next;
    logic [RW-1:0]         r_raw, r_c1, r_c2;
    logic [DATA_WIDTH-1:0] r_fix;

    // S1 input: magnitude of the signed wide word
    always_comb begin
        a_abs = x[WW-1] ? (~x + 1'b1) : x;
    end

    // S2 input: quotient estimate from the top half of the full-width product
    always_comb begin
        q_next = WW'(((2*WW)'(a1) * (2*WW)'(M_K)) >> WW);
    end

    // S3 input: remainder (estimate is at most 2 short), then apply the sign
    always_comb begin
        r_raw = RW'(a2 - q2 * Q_WW);
        r_c1  = (r_raw >= Q_RW) ? r_raw - Q_RW : r_raw;
        r_c2  = (r_c1 >= Q_RW) ? r_c1 - Q_RW : r_c1;
        r_fix = DATA_WIDTH'((s2 && r_c2 != '0) ? Q_RW - r_c2 : r_c2);
    end

    // Stage registers, each advancing only on its enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            a1 <= '0;
            s2 <= 1'b0;
            a2 <= '0;
            q2 <= '0;
            r  <= '0;
        end else begin
            if (en1) begin
                s1 <= x[WW-1];
                a1 <= a_abs;
            end
            if (en2) begin
                s2 <= s1;
                a2 <= a1;
                q2 <= q_next;
            end
            if (en3) begin
                r <= r_fix;
            end
        end
    end

endmodule

// File: rtl/ntt_bu_reduce.sv
// Modular reduction stage after the NTT butterfly: reduces the signed
// double-width sum/difference pair to canonical residues in [0, Q) with a
// 3-cycle valid/ready pipeline (bubbles collapse, 1 pair/cycle when unstalled).
// Optional build macro NTT_BU_REDUCE_ERRCHK_EN adds a sticky err_o flag for
// accepted inputs outside the supported signed range.
module ntt_bu_reduce
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = COEF_W,
    parameter int VAL_Q      = Q
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [2*DATA_WIDTH-1:0] sum_i,
    input  logic [2*DATA_WIDTH-1:0] diff_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   sum_o,
    output logic [DATA_WIDTH-1:0]   diff_o
`ifdef NTT_BU_REDUCE_ERRCHK_EN
    ,
    output logic                    err_o
`endif
);

    localparam int STAGES = 3;
    localparam int WW     = 2 * DATA_WIDTH;

    logic [STAGES:1]            vld_pipe;
    logic                       ld1, ld2, ld3;
    logic                       en1, en2, en3;
    logic [1:0][WW-1:0]         lane_x;
    logic [1:0][DATA_WIDTH-1:0] lane_r;

    // A stage may load when it is empty or its successor is loading
    always_comb begin
        ld3 = !vld_pipe[3] | out_ready_i;
        ld2 = !vld_pipe[2] | ld3;
        ld1 = !vld_pipe[1] | ld2;
        en1 = ld1 & in_valid_i;
        en2 = ld2 & vld_pipe[1];
        en3 = ld3 & vld_pipe[2];
    end

    assign in_ready_o  = ld1;
    assign out_valid_o = vld_pipe[3];

    // Valid chain: each bit follows its predecessor when its stage loads
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_pipe <= '0;
        end else begin
            if (ld1) vld_pipe[1] <= in_valid_i;
            if (ld2) vld_pipe[2] <= vld_pipe[1];
            if (ld3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    assign lane_x = {diff_i, sum_i};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lane
            ntt_barrett_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .VAL_Q      (VAL_Q)
            ) u_lane (
                .clk (clk_i),
                .rst (reset_i),
                .en1 (en1),
                .en2 (en2),
                .en3 (en3),
                .x   (lane_x[g]),
                .r   (lane_r[g])
            );
        end
    endgenerate

    assign sum_o  = lane_r[0];
    assign diff_o = lane_r[1];

`ifdef NTT_BU_REDUCE_ERRCHK_EN
    // Supported range is -2^(WW-2) < x < 2^(WW-2): top two bits equal,
    // and the single most-negative value of that window is excluded.
    function automatic logic out_of_range(input logic [WW-1:0] x);
        return (x[WW-1] != x[WW-2]) || (x == {2'b11, {(WW-2){1'b0}}});
    endfunction

    // Sticky range-error flag, cleared only by reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_o <= 1'b0;
        end else if (in_valid_i && in_ready_o &&
                     (out_of_range(sum_i) || out_of_range(diff_i))) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_bu_reduce.sv
// Self-checking bench for ntt_bu_reduce: directed vectors, randomized
// stream against a modulo reference, throughput, stall/reset and (when
// NTT_BU_REDUCE_ERRCHK_EN is defined) the sticky range-error flag.
module tb_ntt_bu_reduce;

    localparam int    DW = 32;
    localparam longint QV = 64'sd8380417;

    typedef struct {
        longint s;
        longint d;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   sum_in = '0;
    logic [63:0]   diff_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] sum_out;
    logic [DW-1:0] diff_out;
`ifdef NTT_BU_REDUCE_ERRCHK_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    pair_t exp_q[$];

    always #5 clk = ~clk;

    ntt_bu_reduce dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sum_i       (sum_in),
        .diff_i      (diff_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum_out),
        .diff_o      (diff_out)
`ifdef NTT_BU_REDUCE_ERRCHK_EN
        ,
        .err_o       (err)
`endif
    );

    // Mathematical residue in [0, Q)
    function automatic longint ref_mod(input longint x);
        longint r;
        r = x % QV;
        if (r < 0) r = r + QV;
        return r;
    endfunction

    // Random in-range value, mixing full-width and small magnitudes
    function automatic longint rand_in();
        longint v;
        if ($urandom_range(0, 3) == 0)
            v = longint'($urandom_range(0, 200000)) - 64'sd100000;
        else
            v = longint'({$urandom(), $urandom()}) >>> 2;
        if (v == -(64'sd1 <<< 62)) v = 0;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || sum_out !== '0 || diff_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b sum=%0d diff=%0d, want 0/0/0",
                     out_valid, sum_out, diff_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        longint        vs[4];
        longint        vd[4];
        logic [DW-1:0] es[4];
        logic [DW-1:0] ed[4];
        int            lat;
        vs[0] = 64'sd8380418;                   vd[0] = -64'sd1;
        es[0] = 32'd1;                          ed[0] = 32'd8380416;
        vs[1] = 64'sd0;                         vd[1] = -64'sd8380417;
        es[1] = 32'd0;                          ed[1] = 32'd0;
        vs[2] = 64'sd25141256;                  vd[2] = 64'sd0;
        es[2] = 32'd5;                          ed[2] = 32'd0;
        vs[3] = (64'sd8380417 <<< 32) + 64'sd7; vd[3] = -((64'sd8380417 <<< 32) + 64'sd7);
        es[3] = 32'd7;                          ed[3] = 32'd8380410;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sum_in = vs[i];
            diff_in = vd[i];
            out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_ready[%0d]: got %b want 1", i, in_ready);
            end
            lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid === 1'b1) lat = k;
            end
            n_checks++;
            if (lat != 3) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat);
            end
            n_checks++;
            if (sum_out !== es[i] || diff_out !== ed[i]) begin
                n_fail++;
                $display("FAIL directed_value[%0d]: sum=%0d diff=%0d want %0d %0d",
                         i, sum_out, diff_out, es[i], ed[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stream(input int n);
        int    sent = 0;
        int    recv = 0;
        int    cyc = 0;
        pair_t p;
        longint a, b;
        exp_q.delete();
        while (recv < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
            a = rand_in();
            b = rand_in();
            sum_in = a;
            diff_in = b;
            out_ready = $urandom_range(0, 1);
            #1;
            if (in_valid && in_ready) begin
                p.s = ref_mod(a);
                p.d = ref_mod(b);
                exp_q.push_back(p);
                sent++;
            end
            if (out_valid && out_ready) begin
                recv++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: output %0d with nothing outstanding", recv);
                end else begin
                    p = exp_q.pop_front();
                    if (sum_out !== DW'(p.s) || diff_out !== DW'(p.d)) begin
                        n_fail++;
                        $display("FAIL stream_value[%0d]: sum=%0d diff=%0d want %0d %0d",
                                 recv, sum_out, diff_out, p.s, p.d);
                    end
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (sent != n || recv != n || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: sent=%0d recv=%0d pending=%0d want %0d/%0d/0",
                     sent, recv, exp_q.size(), n, n);
        end
    endtask

    task automatic test_back_to_back();
        int    first = -1;
        int    last = -1;
        int    nout = 0;
        int    bad_ready = 0;
        int    bad_val = 0;
        pair_t p;
        longint a, b;
        exp_q.delete();
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            in_valid = (k < 20);
            out_ready = 1'b1;
            a = rand_in();
            b = rand_in();
            sum_in = a;
            diff_in = b;
            #1;
            if (in_valid) begin
                if (in_ready !== 1'b1) bad_ready++;
                p.s = ref_mod(a);
                p.d = ref_mod(b);
                exp_q.push_back(p);
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = k;
                last = k;
                nout++;
                if (exp_q.size() == 0) begin
                    bad_val++;
                end else begin
                    p = exp_q.pop_front();
                    if (sum_out !== DW'(p.s) || diff_out !== DW'(p.d)) bad_val++;
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: %0d cycles low, want 0", bad_ready);
        end
        n_checks++;
        if (first != 3 || last != 22 || nout != 20) begin
            n_fail++;
            $display("FAIL b2b_throughput: first=%0d last=%0d n=%0d want 3/22/20",
                     first, last, nout);
        end
        n_checks++;
        if (bad_val != 0) begin
            n_fail++;
            $display("FAIL b2b_value: %0d wrong outputs, want 0", bad_val);
        end
    endtask

    task automatic test_stall_reset();
        int            acc = 0;
        int            unstable = 0;
        logic          held = 1'b0;
        logic [DW-1:0] hs, hd;
        int            late = 0;
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sum_in = 64'sd1000 + c;
            diff_in = -longint'(c) - 64'sd3;
            out_ready = 1'b0;
            #1;
            if (in_ready) acc++;
            if (out_valid === 1'b1) begin
                if (!held) begin
                    held = 1'b1;
                    hs = sum_out;
                    hd = diff_out;
                end else if (sum_out !== hs || diff_out !== hd) begin
                    unstable++;
                end
            end
        end
        n_checks++;
        if (acc != 3 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_fill: accepts=%0d in_ready=%b want 3/0", acc, in_ready);
        end
        n_checks++;
        if (!held || unstable != 0 || hs !== DW'(ref_mod(64'sd1000)) ||
            hd !== DW'(ref_mod(-64'sd3))) begin
            n_fail++;
            $display("FAIL stall_hold: held=%b unstable=%0d sum=%0d diff=%0d want 1/0/%0d/%0d",
                     held, unstable, hs, hd, ref_mod(64'sd1000), ref_mod(-64'sd3));
        end
        // Asynchronous reset away from any clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || sum_out !== '0 || diff_out !== '0) begin
            n_fail++;
            $display("FAIL stall_async_reset: out_valid=%b sum=%0d diff=%0d want 0/0/0",
                     out_valid, sum_out, diff_out);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid !== 1'b0) late++;
        end
        n_checks++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL stall_discard: %0d outputs after reset, want 0", late);
        end
    endtask

`ifdef NTT_BU_REDUCE_ERRCHK_EN
    task automatic test_errchk();
        do_reset();
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset: got %b want 0", err);
        end
        // Lowest in-range value must not trip the flag
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        sum_in = 64'hC000_0000_0000_0001;
        diff_in = 64'h3FFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_in_range: got %b want 0", err);
        end
        @(negedge clk);
        in_valid = 1'b1;
        sum_in = 64'h4000_0000_0000_0000;
        diff_in = 64'd0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b want 1", err);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sum_in = 64'd5;
            diff_in = 64'd9;
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        do_reset();
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b want 0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stream(100);
        do_reset();
        test_back_to_back();
        do_reset();
        test_stall_reset();
`ifdef NTT_BU_REDUCE_ERRCHK_EN
        test_errchk();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
